// File: rtl/wb_stage_pkg.sv
// Shared types and constants for the writeback stage (package wb_pkg).
package wb_pkg;
  localparam int XLEN      = 32;
  localparam int NREG_BITS = 5;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_PC4  = 2'd2
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic                 wr_en;
    logic [NREG_BITS-1:0] rd;
    logic [XLEN-1:0]      data;
  } wb_entry_t;
endpackage

// File: rtl/wb_stage_if.sv
// Memory-stage to writeback-stage handshake bundle.
interface wb_stage_if;
  import wb_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic                 in_reg_wr;
  logic [NREG_BITS-1:0] in_rd;
  logic [1:0]           in_wb_sel;
  logic [XLEN-1:0]      in_alu_result;
  logic [XLEN-1:0]      in_pc4;
  logic [XLEN-1:0]      in_load_data;
  logic [2:0]           in_funct3;

  modport master (
    output in_valid, in_reg_wr, in_rd, in_wb_sel, in_alu_result, in_pc4, in_load_data, in_funct3,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_reg_wr, in_rd, in_wb_sel, in_alu_result, in_pc4, in_load_data, in_funct3,
    output in_ready
  );
endinterface

// File: rtl/wb_stage_load_align.sv
// Combinational load extraction: picks byte/half from the aligned word and extends it.
module load_align
  import wb_pkg::*;
(
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      addr,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data,
  output logic            misaligned
);
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v     = word[{addr, 3'b000} +: 8];
    half_v     = word[{addr[1], 4'b0000} +: 16];
    data       = word;
    misaligned = 1'b0;
    case (funct3)
      F3_LB:  data = {{(XLEN-8){byte_v[7]}}, byte_v};
      F3_LBU: data = {{(XLEN-8){1'b0}}, byte_v};
      F3_LH: begin
        data       = {{(XLEN-16){half_v[15]}}, half_v};
        misaligned = addr[0];
      end
      F3_LHU: begin
        data       = {{(XLEN-16){1'b0}}, half_v};
        misaligned = addr[0];
      end
      // LW and the unused encodings pass the whole word
      default: begin
        data       = word;
        misaligned = (addr != 2'b00);
      end
    endcase
  end
endmodule

// File: rtl/wb_stage.sv
// Writeback stage: result select, 2-entry skid buffer, RF write port and RAW hazard flag.
// Optional WB_BYPASS_EN adds fwd_* outputs and forces hazard low.
module wb_stage
  import wb_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  wb_stage_if.slave            bus,
  input  logic                 rf_ready,
  output logic                 reg_wr,
  output logic [NREG_BITS-1:0] rd,
  output logic [XLEN-1:0]      wr_data,
  input  logic [NREG_BITS-1:0] dec_rs1,
  input  logic [NREG_BITS-1:0] dec_rs2,
  output logic                 hazard,
  output logic                 misalign_err
`ifdef WB_BYPASS_EN
  ,
  output logic                 fwd_valid,
  output logic [NREG_BITS-1:0] fwd_rd,
  output logic [XLEN-1:0]      fwd_data
`endif
);
  wb_entry_t       head, skid, in_entry;
  logic            head_valid, skid_valid;
  logic [XLEN-1:0] load_data;
  logic            load_mis, mis, accept, retire;

  load_align u_align (
    .word       (bus.in_load_data),
    .addr       (bus.in_alu_result[1:0]),
    .funct3     (bus.in_funct3),
    .data       (load_data),
    .misaligned (load_mis)
  );

  assign mis = (bus.in_wb_sel == WB_LOAD) & load_mis;

  always_comb begin
    in_entry.wr_en = bus.in_reg_wr & (bus.in_rd != '0) & ~mis;
    in_entry.rd    = bus.in_rd;
    case (bus.in_wb_sel)
      WB_LOAD: in_entry.data = load_data;
      WB_PC4:  in_entry.data = bus.in_pc4;
      default: in_entry.data = bus.in_alu_result;
    endcase
  end

  assign bus.in_ready = ~skid_valid;
  assign accept       = bus.in_valid & ~skid_valid;
  // entries that do not write retire without waiting for the RF port
  assign retire       = head_valid & (rf_ready | ~head.wr_en);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_valid   <= 1'b0;
      skid_valid   <= 1'b0;
      head         <= '0;
      skid         <= '0;
      misalign_err <= 1'b0;
    end else begin
      if (accept & mis)
        misalign_err <= 1'b1;
      if (retire & skid_valid) begin
        head       <= skid;
        skid_valid <= 1'b0;
      end else if (accept & (retire | ~head_valid)) begin
        head       <= in_entry;
        head_valid <= 1'b1;
      end else if (accept) begin
        skid       <= in_entry;
        skid_valid <= 1'b1;
      end else if (retire) begin
        head_valid <= 1'b0;
      end
    end
  end

  // head register is never cleared on retire, so rd/wr_data hold their last value
  assign reg_wr  = head_valid & head.wr_en & rf_ready;
  assign rd      = head.rd;
  assign wr_data = head.data;

`ifdef WB_BYPASS_EN
  logic skid_fwd;
  assign skid_fwd  = skid_valid & skid.wr_en;
  assign fwd_valid = skid_fwd | (head_valid & head.wr_en);
  assign fwd_rd    = skid_fwd ? skid.rd : head.rd;
  assign fwd_data  = skid_fwd ? skid.data : head.data;
  assign hazard    = 1'b0;
`else
  logic head_hit, skid_hit;
  assign head_hit = head_valid & head.wr_en & ((head.rd == dec_rs1) | (head.rd == dec_rs2));
  assign skid_hit = skid_valid & skid.wr_en & ((skid.rd == dec_rs1) | (skid.rd == dec_rs2));
  assign hazard   = head_hit | skid_hit;
`endif
endmodule
